// File: rtl/audio_fx_pkg.sv
// Shared definitions for the stereo echo effect: mode codes, FSM state
// encodings and the saturating-add helper.
package audio_fx_pkg;

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_DELAY    = 2'b01;
    localparam logic [1:0] MODE_ECHO     = 2'b10;
    localparam logic [1:0] MODE_FEEDBACK = 2'b11;

    // Widest sample the sat helper handles; callers sign-extend into it.
    localparam int SAT_MAX_W = 32;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_CALC  = 3'd3,
        ST_WR    = 3'd4,
        ST_OUT   = 3'd5
    } fx_state_t;

    // Clamp a sign-extended sum to the range of a w-bit signed sample.
    function automatic logic signed [SAT_MAX_W-1:0] sat(
        input logic signed [SAT_MAX_W:0] sum,
        input int unsigned               w
    );
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (w - 1)) - one;
        lo     = -hi - one;
        if (sum > hi)
            return hi[SAT_MAX_W-1:0];
        else if (sum < lo)
            return lo[SAT_MAX_W-1:0];
        else
            return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/audio_delay_ram.sv
// Single-port delay-line RAM, {left,right} packed per word, synchronous read.
module audio_delay_ram #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [2*DATA_W-1:0]   rdata
);

    logic [2*DATA_W-1:0] mem [DEPTH];

    // One access per cycle: write wins, otherwise registered read.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/audio_echo_fx.sv
// Stereo effects stage between codec read and write handshakes: bypass,
// delay, feed-forward echo or feedback echo over a circular delay line.
//
// state | meaning
// CLEAR | zero the delay RAM, one address per cycle (busy=1)
// IDLE  | wait for read_ready, pulse read, latch sample/mode/delay
// RD    | present wp - D to the RAM
// CALC  | form outputs and RAM words, register writedata, flag clip
// WR    | store RAM pair at wp, advance wp
// OUT   | hold writedata until write_ready, pulse write
module audio_echo_fx
    import audio_fx_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 4096,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter int GAIN_SHIFT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              write,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] delay_len,
    output logic              busy,
    output logic              clip
);

    fx_state_t state, state_nxt;

    logic [ADDR_W-1:0]          wp;
    logic [ADDR_W-1:0]          dly;
    logic [ADDR_W-1:0]          clr_cnt;
    logic [ADDR_W-1:0]          ram_addr;
    logic [1:0]                 m;
    logic                       ram_we;
    logic                       ram_re;
    logic [2*DATA_W-1:0]        ram_wdata;
    logic [2*DATA_W-1:0]        ram_rdata;

    logic signed [DATA_W-1:0]   in_l, in_r;
    logic signed [DATA_W-1:0]   dl, dr;
    logic signed [DATA_W-1:0]   dl_att, dr_att;
    logic signed [DATA_W:0]     sum_l, sum_r;
    logic signed [SAT_MAX_W-1:0] sat_full_l, sat_full_r;
    logic signed [DATA_W-1:0]   echo_l, echo_r;
    logic signed [DATA_W-1:0]   out_l, out_r;
    logic signed [DATA_W-1:0]   mem_nxt_l, mem_nxt_r;
    logic signed [DATA_W-1:0]   mem_l, mem_r;
    logic                       clip_nxt;
    logic                       unused_sat_hi;

    audio_delay_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (CLOCK_50),
        .we     (ram_we),
        .re     (ram_re),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (ram_rdata)
    );

    // State register; reset always restarts with a RAM clear.
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state <= ST_CLEAR;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_cnt == '0) state_nxt = ST_IDLE;
            ST_IDLE:  if (read_ready) state_nxt = ST_RD;
            ST_RD:    state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_WR;
            ST_WR:    state_nxt = ST_OUT;
            ST_OUT:   if (write_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // FSM outputs and RAM port mux; handshakes are masked while reset is high
    // so a reset landing in OUT never leaks a write pulse.
    always_comb begin
        read      = 1'b0;
        write     = 1'b0;
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = wp;
        ram_wdata = {mem_l, mem_r};
        case (state)
            ST_CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = ~clr_cnt;
                ram_wdata = '0;
            end
            ST_IDLE:  read = read_ready & ~reset;
            ST_RD: begin
                ram_re   = 1'b1;
                ram_addr = wp - dly;
            end
            ST_WR:    ram_we = 1'b1;
            ST_OUT:   write = write_ready & ~reset;
            default:  ;
        endcase
    end

    // Per-channel arithmetic; D = 0 naturally reads the slot written DEPTH samples ago.
    always_comb begin
        dl         = ram_rdata[2*DATA_W-1:DATA_W];
        dr         = ram_rdata[DATA_W-1:0];
        dl_att     = dl >>> GAIN_SHIFT;
        dr_att     = dr >>> GAIN_SHIFT;
        sum_l      = {in_l[DATA_W-1], in_l} + {dl_att[DATA_W-1], dl_att};
        sum_r      = {in_r[DATA_W-1], in_r} + {dr_att[DATA_W-1], dr_att};
        sat_full_l = sat((SAT_MAX_W+1)'(sum_l), DATA_W);
        sat_full_r = sat((SAT_MAX_W+1)'(sum_r), DATA_W);
        echo_l     = sat_full_l[DATA_W-1:0];
        echo_r     = sat_full_r[DATA_W-1:0];
        out_l      = in_l;
        out_r      = in_r;
        mem_nxt_l  = in_l;
        mem_nxt_r  = in_r;
        clip_nxt   = 1'b0;
        case (m)
            MODE_DELAY: begin
                out_l = dl;
                out_r = dr;
            end
            MODE_ECHO: begin
                out_l    = echo_l;
                out_r    = echo_r;
                clip_nxt = (sum_l[DATA_W] ^ sum_l[DATA_W-1]) | (sum_r[DATA_W] ^ sum_r[DATA_W-1]);
            end
            MODE_FEEDBACK: begin
                out_l     = echo_l;
                out_r     = echo_r;
                mem_nxt_l = echo_l;
                mem_nxt_r = echo_r;
                clip_nxt  = (sum_l[DATA_W] ^ sum_l[DATA_W-1]) | (sum_r[DATA_W] ^ sum_r[DATA_W-1]);
            end
            default: ;
        endcase
    end

    assign unused_sat_hi = ^{sat_full_l[SAT_MAX_W-1:DATA_W], sat_full_r[SAT_MAX_W-1:DATA_W]};

    // Datapath registers: clear down-counter, input latch, output/RAM words, write pointer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clr_cnt         <= '1;
            wp              <= '0;
            dly             <= '0;
            m               <= MODE_BYPASS;
            in_l            <= '0;
            in_r            <= '0;
            mem_l           <= '0;
            mem_r           <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
            clip            <= 1'b0;
        end else begin
            clip <= 1'b0;
            case (state)
                ST_CLEAR: clr_cnt <= clr_cnt - 1'b1;
                ST_IDLE: begin
                    if (read_ready) begin
                        in_l <= readdata_left;
                        in_r <= readdata_right;
                        m    <= mode;
                        dly  <= delay_len;
                    end
                end
                ST_CALC: begin
                    writedata_left  <= out_l;
                    writedata_right <= out_r;
                    mem_l           <= mem_nxt_l;
                    mem_r           <= mem_nxt_r;
                    clip            <= clip_nxt;
                end
                ST_WR:   wp <= wp + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
